// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that shares one 32-bit magnitude comparator among NREQ requesters.
// Build option: define CMP_SIGNED_EN for a two's-complement compare (default is unsigned).

module comparator_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        gt
);
  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);
endmodule

// state | meaning
// IDLE  | waiting for a request; picks the round-robin winner and latches its operands
// CMP   | comparator evaluates the latched operands; result and ack are registered
// RESP  | ack pulse visible to the winner; returns to IDLE
module cmp_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   x_in,
  input  logic [32*NREQ-1:0]   y_in,
  output logic [NREQ-1:0]      ack,
  output logic                 eq_out,
  output logic                 lt_out,
  output logic                 gt_out,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  last, last_nx;
  logic [IDW-1:0]  grant_nx;
  logic [31:0]     x_r, y_r, x_nx, y_nx;
  logic [NREQ-1:0] ack_nx;
  logic            eq_nx, lt_nx, gt_nx, busy_nx;

  logic [IDW-1:0]  win_id, cand;
  logic            win_found;
  logic [31:0]     cmp_a, cmp_b;
  logic            cmp_eq, cmp_lt, cmp_gt;

  // Biasing the sign bit maps signed order onto unsigned order; equality is unaffected.
`ifdef CMP_SIGNED_EN
  assign cmp_a = {~x_r[31], x_r[30:0]};
  assign cmp_b = {~y_r[31], y_r[30:0]};
`else
  assign cmp_a = x_r;
  assign cmp_b = y_r;
`endif

  comparator_32b u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  // Search starts just after the last winner; the index wraps since NREQ is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + IDW'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    grant_nx = grant_id;
    x_nx     = x_r;
    y_nx     = y_r;
    ack_nx   = ack;
    eq_nx    = eq_out;
    lt_nx    = lt_out;
    gt_nx    = gt_out;
    busy_nx  = busy;
    case (state)
      IDLE: begin
        if (win_found) begin
          x_nx     = x_in[32*win_id +: 32];
          y_nx     = y_in[32*win_id +: 32];
          grant_nx = win_id;
          last_nx  = win_id;
          busy_nx  = 1'b1;
          state_nx = CMP;
        end
      end
      CMP: begin
        eq_nx            = cmp_eq;
        lt_nx            = cmp_lt;
        gt_nx            = cmp_gt;
        ack_nx           = '0;
        ack_nx[grant_id] = 1'b1;
        state_nx         = RESP;
      end
      RESP: begin
        ack_nx   = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        ack_nx   = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDW'(NREQ - 1);
      grant_id <= '0;
      x_r      <= '0;
      y_r      <= '0;
      ack      <= '0;
      eq_out   <= 1'b0;
      lt_out   <= 1'b0;
      gt_out   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      grant_id <= grant_nx;
      x_r      <= x_nx;
      y_r      <= y_nx;
      ack      <= ack_nx;
      eq_out   <= eq_nx;
      lt_out   <= lt_nx;
      gt_out   <= gt_nx;
      busy     <= busy_nx;
    end
  end

endmodule
